stop_watch_display: RTL and testbench

//   Downstream display stage of the stop watch. Consumes the 5-bit elapsed-seconds

---
 rtl/stop_watch_display.sv | 181 ++++++++++++++++++
 tb/tb_stop_watch_display.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/stop_watch_display.sv
// Display stage for the stop watch. It converts the 5-bit seconds value to two BCD
// digits using a sequential double-dabble. It then scans a 2-digit 7-segment
// display, blanks a leading zero in the tens place, and blinks the digits while
// the watch is paused (IDLE).
module stop_watch_display #(
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 50
) (
    input  logic       clk,
    input  logic       Rst_i,
    input  logic [4:0] time_i,
    input  logic [2:0] mode_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic [2:0] mode_led_o,
    output logic       busy_o
);

    localparam logic [2:0] MODE_IDLE = 3'b100;
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [12:0]         sr_q;          // {tens nibble, ones nibble, binary}
    logic [2:0]          cnt_q;
    logic [4:0]          last_q;
    logic                valid_q;
    logic [3:0]          tens_q, ones_q;
    logic                need_conv;
    logic                start_en, shift_en, load_en;
    logic [12:0]         sr_adj;

    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [BLINK_W-1:0]  blink_q, blink_d;
    logic                phase_q, phase_d;  // 1 = digits visible
    logic [1:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [2:0]          mode_led_q;
    logic [3:0]          digit_sel;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // A new conversion starts when nothing valid is displayed or the input moved.
    assign need_conv = !valid_q || (time_i != last_q);

    // Conversion FSM state register.
    always_ff @(posedge clk or posedge Rst_i) begin
        if (Rst_i) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    // Conversion FSM next-state logic: five shift steps cover all 5 input bits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:  if (need_conv) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == 3'd4) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    // Conversion FSM outputs.
    always_comb begin
        busy_o   = (state_q != ST_WAIT);
        start_en = (state_q == ST_WAIT) && need_conv;
        shift_en = (state_q == ST_SHIFT);
        load_en  = (state_q == ST_LOAD);
    end

    // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[12:9] >= 4'd5) sr_adj[12:9] = sr_q[12:9] + 4'd3;
        if (sr_q[8:5]  >= 4'd5) sr_adj[8:5]  = sr_q[8:5]  + 4'd3;
    end

    // Conversion datapath: capture, shift, and load into the display digits.
    always_ff @(posedge clk or posedge Rst_i) begin
        if (Rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            if (start_en) begin
                sr_q   <= {8'd0, time_i};
                last_q <= time_i;
                cnt_q  <= '0;
            end
            if (shift_en) begin
                sr_q  <= sr_adj << 1;
                cnt_q <= cnt_q + 3'd1;
            end
            if (load_en) begin
                tens_q  <= sr_q[12:9];
                ones_q  <= sr_q[8:5];
                valid_q <= 1'b1;
            end
        end
    end

    // Scan and blink next-state logic. The segments are derived from the next
    // digit select and the next phase, so seg_o and an_o change on the same edge.
    always_comb begin
        scan_d = scan_q + 1'b1;
        an_d   = an_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            an_d   = {an_q[0], an_q[1]};
        end

        blink_d = '0;
        phase_d = 1'b1;
        if (mode_i == MODE_IDLE) begin
            if (mode_led_q != MODE_IDLE) begin
                // Just paused: restart with the digits visible.
                blink_d = '0;
                phase_d = 1'b1;
            end else if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
                phase_d = phase_q;
            end
        end

        digit_sel = an_d[1] ? tens_q : ones_q;
        seg_d     = seg_code(digit_sel);
        if (!phase_d || (an_d[1] && (tens_q == 4'd0))) seg_d = 7'h00;
    end

    // Display registers.
    always_ff @(posedge clk or posedge Rst_i) begin
        if (Rst_i) begin
            scan_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b1;
            an_q       <= 2'b01;
            seg_q      <= 7'h00;
            mode_led_q <= MODE_IDLE;
        end else begin
            scan_q     <= scan_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            mode_led_q <= mode_i;
        end
    end

    assign seg_o      = seg_q;
    assign an_o       = an_q;
    assign mode_led_o = mode_led_q;

endmodule

// File: tb/tb_stop_watch_display.sv
// Directed bench for stop_watch_display: a vector table for the conversion and
// scan behaviour, followed by hand-written blink and mid-conversion reset sequences.
module tb_stop_watch_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] time_i = 5'd0;
    logic [2:0] mode_i = 3'b010;
    logic [6:0] seg_o;
    logic [1:0] an_o;
    logic [2:0] mode_led_o;
    logic       busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    stop_watch_display #(.SCAN_DIV(1), .BLINK_DIV(50)) dut (
        .clk        (clk),
        .Rst_i      (rst),
        .time_i     (time_i),
        .mode_i     (mode_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .mode_led_o (mode_led_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] t;
        logic [2:0] mode;
        int         ncyc;
        logic [6:0] seg;
        logic [1:0] an;
        logic       busy;
        logic [2:0] led;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        logic       on;
        logic       found;

        //         rst  time   mode    n   seg    an     busy  led
        vecs[0]  = '{1'b1, 5'd0,  3'b010, 2,  7'h00, 2'b01, 1'b0, 3'b100}; // held in reset
        vecs[1]  = '{1'b0, 5'd0,  3'b010, 1,  7'h00, 2'b10, 1'b1, 3'b010}; // conversion starts
        vecs[2]  = '{1'b0, 5'd0,  3'b010, 6,  7'h00, 2'b10, 1'b0, 3'b010}; // load on 7th edge
        vecs[3]  = '{1'b0, 5'd0,  3'b010, 1,  7'h3F, 2'b01, 1'b0, 3'b010}; // ones shows 0
        vecs[4]  = '{1'b0, 5'd23, 3'b001, 1,  7'h00, 2'b10, 1'b1, 3'b001}; // 23 captured
        vecs[5]  = '{1'b0, 5'd23, 3'b001, 5,  7'h3F, 2'b01, 1'b1, 3'b001}; // still busy
        vecs[6]  = '{1'b0, 5'd23, 3'b001, 1,  7'h00, 2'b10, 1'b0, 3'b001}; // busy drops
        vecs[7]  = '{1'b0, 5'd23, 3'b001, 1,  7'h4F, 2'b01, 1'b0, 3'b001}; // ones 3
        vecs[8]  = '{1'b0, 5'd23, 3'b001, 1,  7'h5B, 2'b10, 1'b0, 3'b001}; // tens 2
        vecs[9]  = '{1'b0, 5'd31, 3'b001, 8,  7'h4F, 2'b10, 1'b0, 3'b001}; // tens 3
        vecs[10] = '{1'b0, 5'd31, 3'b001, 1,  7'h06, 2'b01, 1'b0, 3'b001}; // ones 1
        vecs[11] = '{1'b0, 5'd0,  3'b001, 8,  7'h3F, 2'b01, 1'b0, 3'b001}; // wrap to 0
        vecs[12] = '{1'b0, 5'd0,  3'b001, 1,  7'h00, 2'b10, 1'b0, 3'b001}; // tens blank
        vecs[13] = '{1'b0, 5'd15, 3'b001, 2,  7'h00, 2'b10, 1'b1, 3'b001}; // 15 in flight
        vecs[14] = '{1'b0, 5'd16, 3'b001, 14, 7'h06, 2'b10, 1'b0, 3'b001}; // 16 tens
        vecs[15] = '{1'b0, 5'd16, 3'b001, 1,  7'h7D, 2'b01, 1'b0, 3'b001}; // 16 ones
        vecs[16] = '{1'b0, 5'd7,  3'b001, 8,  7'h07, 2'b01, 1'b0, 3'b001}; // 7 shown

        for (int i = 0; i < 17; i++) begin
            rst    = vecs[i].rst;
            time_i = vecs[i].t;
            mode_i = vecs[i].mode;
            repeat (vecs[i].ncyc) tick();
            chk($sformatf("vec%0d seg", i),  seg_o,      vecs[i].seg);
            chk($sformatf("vec%0d an", i),   an_o,       vecs[i].an);
            chk($sformatf("vec%0d busy", i), busy_o,     vecs[i].busy);
            chk($sformatf("vec%0d led", i),  mode_led_o, vecs[i].led);
            $display("[TB] vec%0d rst=%0d time=%0d mode=%b -> seg=%h an=%b busy=%0d led=%b",
                     i, rst, time_i, mode_i, seg_o, an_o, busy_o, mode_led_o);
        end

        // Pause with 7 showing: 50 cycles visible, 50 blanked, repeating.
        mode_i = 3'b100;
        for (int k = 0; k < 160; k++) begin
            tick();
            exp_an  = (k % 2 == 0) ? 2'b10 : 2'b01;
            on      = ((k / 50) % 2) == 0;
            exp_seg = (exp_an == 2'b01 && on) ? 7'h07 : 7'h00;
            chk($sformatf("blink%0d an", k),  an_o,  exp_an);
            chk($sformatf("blink%0d seg", k), seg_o, exp_seg);
        end
        $display("[TB] blink sequence done, seg=%h an=%b", seg_o, an_o);

        // Resume while blanked: digits come back on the next edge.
        mode_i = 3'b001;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_an  = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_seg = (exp_an == 2'b01) ? 7'h07 : 7'h00;
            chk($sformatf("resume%0d an", k),  an_o,  exp_an);
            chk($sformatf("resume%0d seg", k), seg_o, exp_seg);
        end
        chk("resume led", mode_led_o, 3'b001);
        $display("[TB] resume done, seg=%h an=%b led=%b", seg_o, an_o, mode_led_o);

        // Reset in the middle of converting 9.
        time_i = 5'd9;
        tick();
        tick();
        chk("pre-reset busy", busy_o, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst seg",  seg_o,      7'h00);
        chk("async rst an",   an_o,       2'b01);
        chk("async rst busy", busy_o,     1'b0);
        chk("async rst led",  mode_led_o, 3'b100);
        $display("[TB] async reset seg=%h an=%b busy=%0d led=%b", seg_o, an_o, busy_o, mode_led_o);
        tick();
        tick();
        rst   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (an_o == 2'b01 && seg_o == 7'h6F) found = 1'b1;
        end
        chk("post-reset ones 9 within 8", found, 1'b1);
        $display("[TB] post-reset conversion of 9 seen=%0d", found);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
